hazard_ctrl: RTL

Pipeline hazard and sequencing controller for the five-stage pipelined core. It drives the enable (stall) and reset (flush) inputs of every inter-stage pipeline register, including the decode-to-execute control register, and generates the E-stage forwarding selects. It also sequences pipeline warm-up after reset and freezes the pipeline while data memory is not ready. A timeout watchdog on memory waits raises an error pulse.

---
 rtl/pipeline_pkg.sv | 42 ++++
 rtl/hazard_ctrl_forward_unit.sv | 38 +++
 rtl/hazard_ctrl.sv | 237 +++++++++++++++++++++++
 3 files changed

// File: rtl/pipeline_pkg.sv
// -----------------------------------------------------------------------------
// pipeline_pkg
// Shared types and constants for the pipeline hazard controller.
//   hz_state_t : controller FSM states (BOOT, RUN, MEM_WAIT)
//   RES_MEM    : ResultSrcE encoding that marks a load in E
//   FWD_*      : E-stage operand forwarding select encodings
//   fwd_select : one operand's forwarding decision (M beats W, x0 never forwarded)
// -----------------------------------------------------------------------------
package pipeline_pkg;

    typedef enum logic [1:0] {
        BOOT     = 2'd0,
        RUN      = 2'd1,
        MEM_WAIT = 2'd2
    } hz_state_t;

    localparam logic [1:0] RES_MEM = 2'b01;

    localparam logic [1:0] FWD_RF = 2'b00;
    localparam logic [1:0] FWD_W  = 2'b01;
    localparam logic [1:0] FWD_M  = 2'b10;

    // The most recent producer wins, so M is checked before W. Register x0 is
    // hard-wired to zero and must never be forwarded.
    function automatic logic [1:0] fwd_select(
        input logic [4:0] rs,
        input logic [4:0] rd_m,
        input logic       wr_m,
        input logic [4:0] rd_w,
        input logic       wr_w
    );
        logic [1:0] sel;
        sel = FWD_RF;
        if (wr_m && (rd_m != 5'd0) && (rd_m == rs)) begin
            sel = FWD_M;
        end else if (wr_w && (rd_w != 5'd0) && (rd_w == rs)) begin
            sel = FWD_W;
        end
        return sel;
    endfunction

endpackage

// File: rtl/hazard_ctrl_forward_unit.sv
// -----------------------------------------------------------------------------
// forward_unit
// Purely combinational E-stage forwarding selects, one comparator set per
// source operand.
// Ports:
//   Rs1E, Rs2E            in  : E-stage source registers
//   RdM, RdW              in  : M / W destination registers
//   RegWriteM, RegWriteW  in  : nonzero means the stage writes the register file
//   ForwardAE, ForwardBE  out : 00 register file, 01 W result, 10 M result
// -----------------------------------------------------------------------------
module forward_unit (
    input  logic [4:0] Rs1E,
    input  logic [4:0] Rs2E,
    input  logic [4:0] RdM,
    input  logic [4:0] RdW,
    input  logic [2:0] RegWriteM,
    input  logic [2:0] RegWriteW,
    output logic [1:0] ForwardAE,
    output logic [1:0] ForwardBE
);
    import pipeline_pkg::*;

    logic [4:0] rs_e    [2];
    logic [1:0] fwd_sel [2];

    assign rs_e[0] = Rs1E;
    assign rs_e[1] = Rs2E;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_operand
            assign fwd_sel[gi] = fwd_select(rs_e[gi], RdM, |RegWriteM, RdW, |RegWriteW);
        end
    endgenerate

    assign ForwardAE = fwd_sel[0];
    assign ForwardBE = fwd_sel[1];

endmodule

// File: rtl/hazard_ctrl.sv
// -----------------------------------------------------------------------------
// hazard_ctrl
// Hazard and sequencing controller for the five-stage pipeline: drives the
// stall (enable) and flush (bubble) controls of every stage register, the
// E-stage forwarding selects, post-reset warm-up flushing, memory-wait freeze
// and a memory-wait timeout watchdog.
//
// Parameters:
//   BOOT_CYCLES (1..15)    flush cycles after reset release
//   MEM_TIMEOUT (1..65535) memory-wait cycles before mem_error pulses
// Ports:
//   clk, rst (asynchronous, active-low)
//   Rs1D/Rs2D, Rs1E/Rs2E/RdE, RdM, RdW    register specifiers per stage
//   RegWriteE/M/W, ResultSrcE, PCSrcE       pipeline control from E/M/W
//   MemReqM, mem_ready                      data memory handshake
//   StallF/D/E/M, FlushD/E/W                stage register controls (same cycle)
//   ForwardAE/BE                            forwarding selects
//   mem_error                               registered one-cycle timeout pulse
//   perf_stall/perf_flush/perf_memwait      event counters
// Build option: define HAZARD_PERF_EN to enable the performance counters;
// without it the perf ports are tied to zero.
// -----------------------------------------------------------------------------
module hazard_ctrl #(
    parameter int BOOT_CYCLES = 4,
    parameter int MEM_TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  Rs1D,
    input  logic [4:0]  Rs2D,
    input  logic [4:0]  Rs1E,
    input  logic [4:0]  Rs2E,
    input  logic [4:0]  RdE,
    input  logic [4:0]  RdM,
    input  logic [4:0]  RdW,
    input  logic [2:0]  RegWriteE,
    input  logic [2:0]  RegWriteM,
    input  logic [2:0]  RegWriteW,
    input  logic [1:0]  ResultSrcE,
    input  logic        PCSrcE,
    input  logic        MemReqM,
    input  logic        mem_ready,
    output logic        StallF,
    output logic        StallD,
    output logic        StallE,
    output logic        StallM,
    output logic        FlushD,
    output logic        FlushE,
    output logic        FlushW,
    output logic [1:0]  ForwardAE,
    output logic [1:0]  ForwardBE,
    output logic        mem_error,
    output logic [31:0] perf_stall,
    output logic [31:0] perf_flush,
    output logic [31:0] perf_memwait
);
    import pipeline_pkg::*;

    localparam logic [3:0]  BOOT_LAST    = 4'(BOOT_CYCLES - 1);
    localparam logic [15:0] TIMEOUT_LAST = 16'(MEM_TIMEOUT - 1);
    localparam logic [15:0] TIMEOUT_SAT  = 16'(MEM_TIMEOUT);

    hz_state_t   state_q, state_d;
    logic [3:0]  boot_cnt_q, boot_cnt_d;
    logic [15:0] wait_cnt_q, wait_cnt_d;
    logic        mem_error_q, mem_error_d;

    logic mem_stall;
    logic lw_stall;

    // The E-stage write enable is not needed: a load in E is identified by
    // ResultSrcE alone.
    logic unused_regwrite_e;
    assign unused_regwrite_e = ^RegWriteE;

    assign mem_stall = MemReqM & ~mem_ready;
    assign lw_stall  = (ResultSrcE == RES_MEM) && (RdE != 5'd0) &&
                       ((RdE == Rs1D) || (RdE == Rs2D));

    // ------------------------------------------------------------------
    // Stage controls: combinational so they act in the current cycle.
    // Priority: boot > memory freeze > branch > load-use.
    // ------------------------------------------------------------------
    always_comb begin
        StallF = 1'b0;
        StallD = 1'b0;
        StallE = 1'b0;
        StallM = 1'b0;
        FlushD = 1'b0;
        FlushE = 1'b0;
        FlushW = 1'b0;
        if (state_q == BOOT) begin
            StallF = 1'b1;
            FlushD = 1'b1;
            FlushE = 1'b1;
            FlushW = 1'b1;
        end else if (mem_stall) begin
            // Freeze everything up to M; W gets a bubble so the stalled
            // access is not written back twice.
            StallF = 1'b1;
            StallD = 1'b1;
            StallE = 1'b1;
            StallM = 1'b1;
            FlushW = 1'b1;
        end else begin
            if (lw_stall) begin
                StallF = 1'b1;
                StallD = 1'b1;
                FlushE = 1'b1;
            end
            // A taken branch squashes the instructions behind it, so
            // holding F/D for a load-use hazard would be pointless.
            if (PCSrcE) begin
                StallF = 1'b0;
                StallD = 1'b0;
                FlushD = 1'b1;
                FlushE = 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // FSM next state and counters
    // ------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        boot_cnt_d  = boot_cnt_q;
        wait_cnt_d  = wait_cnt_q;
        mem_error_d = 1'b0;
        case (state_q)
            BOOT: begin
                if (boot_cnt_q == BOOT_LAST) begin
                    state_d = RUN;
                end else begin
                    boot_cnt_d = boot_cnt_q + 4'd1;
                end
            end
            RUN: begin
                if (mem_stall) begin
                    state_d    = MEM_WAIT;
                    wait_cnt_d = 16'd0;
                end
            end
            MEM_WAIT: begin
                if (mem_ready || !MemReqM) begin
                    state_d = RUN;
                end
                // Counting stops one past the trigger value so the pulse
                // fires exactly once per wait.
                if (wait_cnt_q != TIMEOUT_SAT) begin
                    wait_cnt_d = wait_cnt_q + 16'd1;
                end
                if (wait_cnt_q == TIMEOUT_LAST) begin
                    mem_error_d = 1'b1;
                end
            end
            default: begin
                state_d = BOOT;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= BOOT;
            boot_cnt_q  <= 4'd0;
            wait_cnt_q  <= 16'd0;
            mem_error_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            boot_cnt_q  <= boot_cnt_d;
            wait_cnt_q  <= wait_cnt_d;
            mem_error_q <= mem_error_d;
        end
    end

    assign mem_error = mem_error_q;

    // ------------------------------------------------------------------
    // Forwarding (active in every state)
    // ------------------------------------------------------------------
    forward_unit u_forward (
        .Rs1E      (Rs1E),
        .Rs2E      (Rs2E),
        .RdM       (RdM),
        .RdW       (RdW),
        .RegWriteM (RegWriteM),
        .RegWriteW (RegWriteW),
        .ForwardAE (ForwardAE),
        .ForwardBE (ForwardBE)
    );

    // ------------------------------------------------------------------
    // Performance counters
    // ------------------------------------------------------------------
`ifdef HAZARD_PERF_EN
    logic        active;
    logic        lw_applied;
    logic        br_applied;
    logic [31:0] perf_stall_q, perf_stall_d;
    logic [31:0] perf_flush_q, perf_flush_d;
    logic [31:0] perf_memwait_q, perf_memwait_d;

    // Only events that actually reach the stage controls are counted: the
    // memory freeze masks both hazards and a branch masks load-use.
    assign active     = (state_q != BOOT);
    assign lw_applied = active & ~mem_stall & lw_stall & ~PCSrcE;
    assign br_applied = active & ~mem_stall & PCSrcE;

    always_comb begin
        perf_stall_d   = perf_stall_q   + {31'd0, lw_applied};
        perf_flush_d   = perf_flush_q   + {31'd0, br_applied};
        perf_memwait_d = perf_memwait_q + {31'd0, active & mem_stall};
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            perf_stall_q   <= 32'd0;
            perf_flush_q   <= 32'd0;
            perf_memwait_q <= 32'd0;
        end else begin
            perf_stall_q   <= perf_stall_d;
            perf_flush_q   <= perf_flush_d;
            perf_memwait_q <= perf_memwait_d;
        end
    end

    assign perf_stall   = perf_stall_q;
    assign perf_flush   = perf_flush_q;
    assign perf_memwait = perf_memwait_q;
`else
    assign perf_stall   = 32'd0;
    assign perf_flush   = 32'd0;
    assign perf_memwait = 32'd0;
`endif

endmodule
